// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: fetch/decode/exec/mem/wb sequencing
// with memory-wait timeout, stall freeze and retired-instruction count.
module multicycle_controller #(
  parameter int ALUOP_W  = 3,
  parameter int MAX_WAIT = 8,
  parameter int JUMP_EN  = 1,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         Opcode,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic               Jump,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               instr_done,
  output logic               illegal,
  output logic               timeout,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam int WC_W =
    (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam logic TO_EN = (MAX_WAIT > 0);
  localparam logic JMP_EN = (JUMP_EN != 0);

  logic [2:0]      state_q;
  logic [2:0]      state_d;
  logic [6:0]      op_q;
  logic [WC_W-1:0] wcnt;
  logic [2:0]      alu_op;
  logic            set_ill;
  logic            set_to;
  logic            to_hit;
  logic            retire_src;

  logic is_r, is_i, is_lw, is_sw;
  logic is_br, is_jmp, is_lui, legal;

  assign is_r   = (op_q == OP_R);
  assign is_i   = (op_q == OP_I);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_br  = (op_q == OP_BR);
  assign is_jmp = JMP_EN &&
                  (op_q == OP_JAL ||
                   op_q == OP_JALR);
  assign is_lui = JMP_EN && (op_q == OP_LUI);
  assign legal  = is_r | is_i | is_lw | is_sw |
                  is_br | is_jmp | is_lui;

  assign to_hit = TO_EN && !mem_ready &&
                  (wcnt == WC_LAST);

  assign retire_src = (state_q == EXEC) ||
                      (state_q == MEM)  ||
                      (state_q == WB);

  assign ALUOp = ALUOP_W'(alu_op);
  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    alu_op     = 3'b000;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    instr_done = 1'b0;
    set_ill    = 1'b0;
    set_to     = 1'b0;

    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        if (to_hit) begin
          state_d = TRAP;
          set_to  = 1'b1;
        end else if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          set_ill = 1'b1;
        end
      end
      EXEC: begin
        unique case (1'b1)
          is_r: begin
            alu_op  = 3'b010;
            state_d = WB;
          end
          is_i: begin
            alu_op  = 3'b000;
            ALUSrc  = 1'b1;
            state_d = WB;
          end
          is_lw, is_sw: begin
            alu_op  = 3'b100;
            ALUSrc  = 1'b1;
            state_d = MEM;
          end
          is_br: begin
            alu_op  = 3'b001;
            Branch  = 1'b1;
            state_d = FETCH;
          end
          is_jmp: begin
            alu_op   = 3'b100;
            Jump     = 1'b1;
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            state_d  = FETCH;
          end
          is_lui: begin
            alu_op  = 3'b011;
            ALUSrc  = 1'b1;
            state_d = WB;
          end
          default: begin
            state_d = TRAP;
            set_ill = 1'b1;
          end
        endcase
      end
      MEM: begin
        MemRead  = is_lw;
        MemWrite = !is_lw;
        if (to_hit) begin
          state_d = TRAP;
          set_to  = 1'b1;
        end else if (mem_ready) begin
          state_d = is_lw ? WB : FETCH;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        MemtoReg = is_lw;
        state_d  = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase

    // A frozen pipeline must not commit anything this cycle.
    if (stall) begin
      state_d  = state_q;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      set_ill  = 1'b0;
      set_to   = 1'b0;
    end

    instr_done = !stall && retire_src &&
                 (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      wcnt    <= '0;
      instret <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else if (!stall) begin
      state_q <= state_d;
      if (IRWrite)
        op_q <= Opcode;
      if (state_d != state_q)
        wcnt <= '0;
      else if (!mem_ready)
        wcnt <= wcnt + WC_W'(1);
      if (instr_done)
        instret <= instret + CNT_W'(1);
      if (set_ill)
        illegal <= 1'b1;
      if (set_to)
        timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: two controller configurations share one random stimulus
// stream and are checked every cycle against an instruction-path model.
module tb_multicycle_controller;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] I    = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef enum int {
    C_BAD, C_R, C_I, C_LW, C_SW,
    C_BR, C_JMP, C_LUI
  } cls_t;

  typedef struct packed {
    logic       src, m2r, rw, mr, mw;
    logic       br, jmp, pcw, irw, done;
    logic [3:0] aop;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;

  logic o_src[2], o_m2r[2], o_rw[2], o_mr[2];
  logic o_mw[2], o_br[2], o_jmp[2], o_pcw[2];
  logic o_irw[2], o_done[2], o_ill[2], o_tmo[2];
  logic [2:0] o_st[2];
  logic [2:0] aop_a;
  logic [3:0] aop_b;
  logic [3:0] ret_a;
  logic [7:0] ret_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .ALUOP_W(3), .MAX_WAIT(8),
    .JUMP_EN(1), .CNT_W(4)
  ) dut_a (
    .clk(clk), .reset(reset),
    .Opcode(opcode), .mem_ready(mem_ready),
    .stall(stall),
    .ALUSrc(o_src[0]), .MemtoReg(o_m2r[0]),
    .RegWrite(o_rw[0]), .MemRead(o_mr[0]),
    .MemWrite(o_mw[0]), .Branch(o_br[0]),
    .Jump(o_jmp[0]), .PCWrite(o_pcw[0]),
    .IRWrite(o_irw[0]), .instr_done(o_done[0]),
    .illegal(o_ill[0]), .timeout(o_tmo[0]),
    .ALUOp(aop_a), .state(o_st[0]),
    .instret(ret_a)
  );

  multicycle_controller #(
    .ALUOP_W(4), .MAX_WAIT(3),
    .JUMP_EN(0), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset(reset),
    .Opcode(opcode), .mem_ready(mem_ready),
    .stall(stall),
    .ALUSrc(o_src[1]), .MemtoReg(o_m2r[1]),
    .RegWrite(o_rw[1]), .MemRead(o_mr[1]),
    .MemWrite(o_mw[1]), .Branch(o_br[1]),
    .Jump(o_jmp[1]), .PCWrite(o_pcw[1]),
    .IRWrite(o_irw[1]), .instr_done(o_done[1]),
    .illegal(o_ill[1]), .timeout(o_tmo[1]),
    .ALUOp(aop_b), .state(o_st[1]),
    .instret(ret_b)
  );

  function automatic int je(int i);
    return (i == 0) ? 1 : 0;
  endfunction
  function automatic int mw(int i);
    return (i == 0) ? 8 : 3;
  endfunction
  function automatic int cw(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int classify(
    logic [6:0] o, int j);
    case (o)
      R:         return C_R;
      I:         return C_I;
      LW:        return C_LW;
      SW:        return C_SW;
      BR:        return C_BR;
      JAL, JALR: return j ? C_JMP : C_BAD;
      LUI:       return j ? C_LUI : C_BAD;
      default:   return C_BAD;
    endcase
  endfunction

  // Phases an instruction walks through:
  // 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback.
  function automatic int plen(int c);
    if (c == C_BR || c == C_JMP) return 3;
    if (c == C_LW) return 5;
    return 4;
  endfunction
  function automatic int phase(int idx, int c);
    if (idx < 3) return idx;
    if (idx == 3 && (c == C_LW || c == C_SW))
      return 3;
    return 4;
  endfunction

  int m_idx[2], m_cls[2], m_wc[2], m_ret[2];
  bit m_trap[2], m_ill[2], m_tmo[2];
  bit armed = 1'b0;

  task automatic advance(input int i);
    m_idx[i]++;
    m_wc[i] = 0;
    if (m_idx[i] == plen(m_cls[i])) begin
      m_idx[i] = 0;
      m_ret[i] = (m_ret[i] + 1) % (1 << cw(i));
    end
  endtask

  task automatic wait_tick(input int i);
    if (mw(i) > 0 && m_wc[i] == mw(i) - 1) begin
      m_trap[i] = 1'b1;
      m_tmo[i]  = 1'b1;
    end else begin
      m_wc[i]++;
    end
  endtask

  task automatic model_step(input int i);
    case (phase(m_idx[i], m_cls[i]))
      0: if (mem_ready) begin
           m_cls[i] = classify(opcode, je(i));
           m_idx[i] = 1;
           m_wc[i]  = 0;
         end else wait_tick(i);
      1: if (m_cls[i] == C_BAD) begin
           m_trap[i] = 1'b1;
           m_ill[i]  = 1'b1;
         end else m_idx[i] = 2;
      3: if (mem_ready) advance(i);
         else wait_tick(i);
      default: advance(i);
    endcase
  endtask

  function automatic outs_t expect_outs(int i);
    outs_t e = '0;
    int c = m_cls[i];
    if (!m_trap[i]) begin
      case (phase(m_idx[i], c))
        0: begin
          e.mr  = 1'b1;
          e.irw = mem_ready;
          e.pcw = mem_ready;
        end
        2: begin
          case (c)
            C_R:   e.aop = 4'd2;
            C_I:   e.src = 1'b1;
            C_LW, C_SW: begin
              e.aop = 4'd4; e.src = 1'b1;
            end
            C_BR: begin
              e.aop = 4'd1; e.br = 1'b1;
              e.done = 1'b1;
            end
            C_JMP: begin
              e.aop = 4'd4; e.jmp = 1'b1;
              e.rw = 1'b1; e.pcw = 1'b1;
              e.done = 1'b1;
            end
            C_LUI: begin
              e.aop = 4'd3; e.src = 1'b1;
            end
            default: ;
          endcase
        end
        3: begin
          e.mr   = (c == C_LW);
          e.mw   = (c == C_SW);
          e.done = (c == C_SW) && mem_ready;
        end
        4: begin
          e.rw   = 1'b1;
          e.m2r  = (c == C_LW);
          e.done = 1'b1;
        end
        default: ;
      endcase
    end
    if (stall) begin
      e.rw = 0; e.mw = 0; e.pcw = 0;
      e.irw = 0; e.done = 0;
    end
    return e;
  endfunction

  function automatic outs_t actual(int i);
    outs_t a;
    a.src  = o_src[i];  a.m2r = o_m2r[i];
    a.rw   = o_rw[i];   a.mr  = o_mr[i];
    a.mw   = o_mw[i];   a.br  = o_br[i];
    a.jmp  = o_jmp[i];  a.pcw = o_pcw[i];
    a.irw  = o_irw[i];  a.done = o_done[i];
    a.aop  = (i == 0) ? {1'b0, aop_a} : aop_b;
    return a;
  endfunction

  task automatic chk(input string nm, input int i,
    input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h @%0t",
               nm, i, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_idx[i] = 0; m_cls[i] = C_BAD;
        m_wc[i] = 0;  m_ret[i] = 0;
        m_trap[i] = 0; m_ill[i] = 0;
        m_tmo[i] = 0;
      end else if (armed && !stall && !m_trap[i]) begin
        model_step(i);
      end
    end
    if (reset) armed = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        int st;
        st = m_trap[i] ? 5 : phase(m_idx[i], m_cls[i]);
        chk("outs", i, 32'(actual(i)),
            32'(expect_outs(i)));
        chk("state", i, 32'(o_st[i]), 32'(st));
        chk("illegal", i, 32'(o_ill[i]), 32'(m_ill[i]));
        chk("timeout", i, 32'(o_tmo[i]), 32'(m_tmo[i]));
        chk("instret", i,
            (i == 0) ? 32'(ret_a) : 32'(ret_b),
            32'(m_ret[i]));
      end
    end
  end

  task automatic step(input logic r, input logic [6:0] o,
                      input logic m, input logic s);
    @(posedge clk);
    #1;
    reset = r; opcode = o; mem_ready = m; stall = s;
    @(negedge clk);
  endtask

  logic [6:0] pool[9];

  initial begin
    pool = '{R, I, LW, SW, BR, JAL, JALR, LUI, BAD};

    // Reset state, then one R-type with no wait states.
    step(1, R, 0, 0);
    step(0, R, 0, 0);
    chk("rst_state", 0, 32'(o_st[0]), 0);
    chk("rst_memread", 0, 32'(o_mr[0]), 1);
    chk("rst_irwrite", 0, 32'(o_irw[0]), 0);
    chk("rst_aluop", 0, 32'(aop_a), 0);
    step(0, R, 1, 0);
    chk("r_f_irw", 0, 32'(o_irw[0]), 1);
    step(0, R, 1, 0);
    chk("r_dec", 0, 32'(o_st[0]), 1);
    chk("r_dec_rw", 0, 32'(o_rw[0]), 0);
    step(0, R, 1, 0);
    chk("r_exec", 0, 32'(o_st[0]), 2);
    chk("r_exec_aop", 0, 32'(aop_a), 2);
    step(0, R, 1, 0);
    chk("r_wb", 0, 32'(o_st[0]), 4);
    chk("r_wb_rw", 0, 32'(o_rw[0]), 1);

    // LW with two wait states in MEM: 7 cycles.
    step(0, LW, 1, 0);
    chk("r_retired", 0, 32'(ret_a), 1);
    chk("lw_f", 0, 32'(o_st[0]), 0);
    step(0, LW, 1, 0);
    step(0, LW, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, LW, (k == 2), 0);
      chk("lw_mem", 0, 32'(o_st[0]), 3);
      chk("lw_mr", 0, 32'(o_mr[0]), 1);
    end
    step(0, LW, 0, 0);
    chk("lw_wb", 0, 32'(o_st[0]), 4);
    chk("lw_m2r", 0, 32'(o_m2r[0]), 1);
    step(0, LW, 0, 0);
    chk("lw_done", 0, 32'(o_st[0]), 0);
    chk("lw_ret", 0, 32'(ret_a), 2);

    // Illegal opcode traps both configurations.
    step(1, BAD, 0, 0);
    step(0, BAD, 1, 0);
    step(0, BAD, 1, 0);
    step(0, BAD, 1, 0);
    chk("bad_trap", 0, 32'(o_st[0]), 5);
    chk("bad_ill", 1, 32'(o_ill[1]), 1);
    step(0, R, 1, 0);
    step(0, R, 1, 0);
    chk("bad_sticky", 0, 32'(o_ill[0]), 1);
    chk("bad_hold", 1, 32'(o_st[1]), 5);
    step(1, JAL, 0, 0);
    step(0, JAL, 0, 0);
    chk("bad_rst", 0, 32'(o_st[0]), 0);
    chk("bad_rst_ill", 0, 32'(o_ill[0]), 0);

    // JAL: legal on dut0, illegal on dut1.
    step(0, JAL, 1, 0);
    step(0, JAL, 1, 0);
    step(0, JAL, 0, 0);
    chk("jal_exec", 0, 32'(o_st[0]), 2);
    chk("jal_jump", 0, 32'(o_jmp[0]), 1);
    chk("jal_aop", 0, 32'(aop_a), 4);
    chk("jal_trap", 1, 32'(o_st[1]), 5);
    chk("jal_ill", 1, 32'(o_ill[1]), 1);
    chk("jal_ret1", 1, 32'(ret_b), 0);
    step(0, JAL, 0, 0);
    chk("jal_ret", 0, 32'(ret_a), 1);

    // Fetch timeout: 8 wait cycles on dut0, 3 on dut1.
    step(1, R, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, R, 0, 0);
      chk("to_wait", 0, 32'(o_st[0]), 0);
      chk("to_irw", 0, 32'(o_irw[0]), 0);
    end
    step(0, R, 1, 0);
    chk("to_trap", 0, 32'(o_st[0]), 5);
    chk("to_flag", 0, 32'(o_tmo[0]), 1);
    chk("to_flag1", 1, 32'(o_tmo[1]), 1);

    // Stall held for 3 cycles in WB.
    step(1, R, 1, 0);
    step(0, R, 1, 0);
    step(0, R, 1, 0);
    step(0, R, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, R, 1, 1);
      chk("stl_wb", 0, 32'(o_st[0]), 4);
      chk("stl_rw", 0, 32'(o_rw[0]), 0);
    end
    step(0, R, 1, 0);
    chk("stl_rel", 0, 32'(o_rw[0]), 1);
    step(0, R, 0, 0);
    chk("stl_fetch", 0, 32'(o_st[0]), 0);

    // Counter wrap with 16 branches, then reset mid-MEM.
    step(1, BR, 0, 0);
    for (int k = 0; k < 15; k++) begin
      step(0, BR, 1, 0);
      step(0, BR, 1, 0);
      step(0, BR, 1, 0);
    end
    step(0, BR, 1, 0);
    chk("wrap_15", 0, 32'(ret_a), 15);
    step(0, BR, 1, 0);
    step(0, BR, 1, 0);
    step(0, SW, 1, 0);
    chk("wrap_0", 0, 32'(ret_a), 0);
    chk("wrap_b", 1, 32'(ret_b), 16);
    step(0, SW, 1, 0);
    step(0, SW, 1, 0);
    step(0, SW, 0, 0);
    chk("sw_mem", 0, 32'(o_st[0]), 3);
    chk("sw_mw", 0, 32'(o_mw[0]), 1);
    step(1, SW, 1, 0);
    step(0, SW, 0, 0);
    chk("sw_rst", 0, 32'(o_st[0]), 0);
    chk("sw_rst_mw", 0, 32'(o_mw[0]), 0);

    // Random traffic with bursty memory readiness.
    for (int k = 0; k < 4000; k++) begin
      int pr;
      int sel;
      logic [6:0] op;
      pr  = ((k / 40) % 3 == 0) ? 15 : 75;
      sel = $urandom_range(0, 9);
      op  = (sel == 9) ? 7'($urandom) : pool[sel];
      step($urandom_range(0, 99) < 2, op,
           $urandom_range(0, 99) < pr,
           $urandom_range(0, 99) < 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, meaning ALUOp width; minimum 3, bits above [2] always 0.
REQ-002 SHALL have parameter MAX_WAIT, default 8, meaning memory-wait cycles before timeout trap; 0 disables the timeout.
REQ-003 SHALL have parameter JUMP_EN, default 1, meaning JAL/JALR/LUI are supported; 0 makes them illegal.
REQ-004 SHALL have parameter CNT_W, default 32, meaning retired-instruction counter width.
REQ-005 SHALL have ports: clk  in  1  clock; all state changes on the rising edge.
REQ-006 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: Opcode  in  7  instruction opcode field from memory read data.
REQ-008 SHALL have ports: mem_ready  in  1  memory has completed the current access.
REQ-009 SHALL have ports: stall  in  1  freeze the FSM and suppress all write enables.
REQ-010 SHALL have outputs, 1 bit each: ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, PCWrite, IRWrite, instr_done, illegal, timeout.
REQ-011 SHALL have outputs: ALUOp  out  ALUOP_W; state  out  3 (current FSM state); instret  out  CNT_W (retired-instruction count).

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; encodings 6 and 7 SHALL go to TRAP.
REQ-013 SHALL drive outputs combinationally from the state register and the latched opcode op_q.
- Unlisted outputs are 0 in every state.
REQ-014 FETCH SHALL assert MemRead and hold while mem_ready=0.
- On mem_ready=1: IRWrite=1, PCWrite=1, op_q<=Opcode, next DECODE.
REQ-015 DECODE SHALL last 1 cycle.
- Legal opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011; when JUMP_EN=1 also JAL 1101111, JALR 1100111, LUI 0110111.
- Legal: next EXEC. Otherwise: next TRAP.
REQ-016 EXEC SHALL drive ALUOp and ALUSrc per opcode, then branch to the next state:
- R: ALUOp=010, ALUSrc=0, next WB.
- I: ALUOp=000, ALUSrc=1, next WB.
- LW/SW: ALUOp=100, ALUSrc=1, next MEM.
- BR: ALUOp=001, Branch=1, next FETCH.
- JAL/JALR: ALUOp=100, Jump=1, RegWrite=1, PCWrite=1, next FETCH.
- LUI: ALUOp=011, ALUSrc=1, next WB.
REQ-017 MEM SHALL assert MemRead (LW) or MemWrite (SW) and hold while mem_ready=0.
- On mem_ready=1: LW next WB, SW next FETCH.
REQ-018 WB SHALL assert RegWrite=1, with MemtoReg=1 only for LW, then go to FETCH.
REQ-019 instr_done SHALL pulse for 1 cycle on every transition into FETCH from EXEC, MEM or WB; instret increments by 1 that same cycle and wraps modulo 2^CNT_W.
REQ-020 Latency: BR/JAL = 3 cycles; R/I/LUI = 4 cycles; SW = 4 cycles; LW = 5 cycles.
- Figures assume zero wait states; each wait cycle adds 1.
REQ-021 A wait counter SHALL clear on entry to FETCH or MEM and increment per cycle with mem_ready=0.
- With MAX_WAIT>0 and counter = MAX_WAIT-1 with mem_ready=0: next TRAP, timeout<=1.
REQ-022 With stall=1, the state, op_q, the wait counter and instret SHALL hold.
- RegWrite, MemWrite, PCWrite and IRWrite are forced to 0; instr_done is 0.
- stall overrides a simultaneous mem_ready=1.
REQ-023 TRAP SHALL keep all enables at 0 and exit only on reset.
- illegal=1 for illegal-opcode entry; timeout=1 for timeout entry; both flags are sticky.

Reset
REQ-024 With reset=1 at a rising edge: state<=FETCH; op_q, wait counter, instret, illegal and timeout <=0, in any state including mid-MEM and TRAP.
REQ-025 reset SHALL take priority over stall and mem_ready.
REQ-026 In the first cycle after reset, outputs SHALL be: MemRead=1, all other enables 0, ALUOp=0.

Verification
REQ-027 R-type 0110011, mem_ready=1 always -> state 0,1,2,4,0; RegWrite=1 only in WB; instret 0->1.
REQ-028 LW with mem_ready low 2 cycles in MEM -> MEM held 3 cycles, MemRead=1 throughout, WB has MemtoReg=1, total 7 cycles.
REQ-029 Opcode 1111111, then JAL with JUMP_EN=0 -> TRAP after DECODE, illegal=1 sticky, instret unchanged, reset returns to FETCH.
REQ-030 MAX_WAIT=8, mem_ready=0 in FETCH -> TRAP after 8 cycles, timeout=1, IRWrite never asserted.
REQ-031 stall=1 for 3 cycles in WB with mem_ready=1 -> state stays 4, RegWrite=0; after release, 1 WB cycle with RegWrite=1, then FETCH.
REQ-032 Preload instret=2^CNT_W-1 (CNT_W=4, 15 BR instructions) -> 16th retire wraps to 0; reset mid-MEM of SW -> MemWrite=0 next cycle, state 0.
